// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes, sequencer states.
package y86_pkg;

    localparam logic [3:0] IHALT    = 4'h0;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] IRRMOVQ  = 4'h2;
    localparam logic [3:0] IIRMOVQ  = 4'h3;
    localparam logic [3:0] IRMMOVQ  = 4'h4;
    localparam logic [3:0] IMRMOVQ  = 4'h5;
    localparam logic [3:0] IOPQ     = 4'h6;
    localparam logic [3:0] IJXX     = 4'h7;
    localparam logic [3:0] ICALL    = 4'h8;
    localparam logic [3:0] IRET     = 4'h9;
    localparam logic [3:0] IPUSHQ   = 4'hA;
    localparam logic [3:0] IPOPQ    = 4'hB;
    localparam logic [3:0] ICODE_MAX = IPOPQ;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    // Instructions that touch data memory and therefore wait for mem_ready.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
               (ic == IRET)    || (ic == IPUSHQ)  || (ic == IPOPQ);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting in MEMORY; expired flags the last allowed cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Saturating wait counter, cleared whenever the sequencer is outside MEMORY.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential Y86 stage sequencer: one stage enable per cycle, fault halting, perf counters.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [3:0]  icode_q,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    state_t     state;
    state_t     state_next;
    logic [2:0] stat_next;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    assign timer_clear  = !rst_n || (state != S_MEMORY);
    assign timer_enable = (state == S_MEMORY);

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and next-status selection; faults fix stat on entry to HALT.
    always_comb begin
        state_next = state;
        stat_next  = stat;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end else if (icode > ICODE_MAX) begin
                    state_next = S_HALT;
                    stat_next  = STAT_INS;
                end else if (icode == IHALT) begin
                    state_next = S_HALT;
                    stat_next  = STAT_HLT;
                end else begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem_icode(icode_q)) begin
                    state_next = S_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        state_next = S_HALT;
                        stat_next  = STAT_ADR;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (timer_expired) begin
                    state_next = S_HALT;
                    stat_next  = STAT_ADR;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD:     state_next = S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // State register with registered Moore outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_en    <= 1'b0;
            decode_en   <= 1'b0;
            exec_en     <= 1'b0;
            mem_en      <= 1'b0;
            wb_en       <= 1'b0;
            pc_en       <= 1'b0;
            stat        <= STAT_AOK;
            halted      <= 1'b0;
            icode_q     <= 4'h0;
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            state     <= state_next;
            stat      <= stat_next;
            fetch_en  <= (state_next == S_FETCH);
            decode_en <= (state_next == S_DECODE);
            exec_en   <= (state_next == S_EXECUTE);
            mem_en    <= (state_next == S_MEMORY) && is_mem_icode(icode_q);
            wb_en     <= (state_next == S_WRITEBACK);
            pc_en     <= (state_next == S_PCUPD);
            halted    <= (state_next == S_HALT);
            if (state == S_FETCH) begin
                icode_q <= icode;
            end
            if ((state != S_IDLE) && (state != S_HALT)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state == S_PCUPD) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule
